// File: rtl/snn_params_pkg.sv
// ============================================================================
//  Module   : snn_params_pkg
//  Purpose  : Shared SNN parameter-bank defaults and readback FSM encoding.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package snn_params_pkg;

    localparam int DEFAULT_NUM_PARAMS = 4;
    localparam int DEFAULT_DATA_W     = 8;
    localparam int DEFAULT_ADDR_W     = 2;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_FETCH        = 2'd1,
        ST_PRESENT      = 2'd2,
        ST_WAIT_RELEASE = 2'd3
    } rb_state_t;

endpackage

`default_nettype wire

// File: rtl/param_readback_cu.sv
// ============================================================================
//  Module   : param_readback_cu
//  Purpose  : Walks the parameter bank and streams each word to the host.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module param_readback_cu
    import snn_params_pkg::*;
#(
    parameter int NUM_PARAMS = DEFAULT_NUM_PARAMS,
    parameter int DATA_W     = DEFAULT_DATA_W,
    parameter int ADDR_W     = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              read_params,
    output logic [ADDR_W-1:0] param_addr,
    input  logic [DATA_W-1:0] param_data,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] C_LAST_ADDR = ADDR_W'(NUM_PARAMS - 1);

    rb_state_t r_state;
    logic      r_done;
    logic      w_handshake;

    assign w_handshake = dout_valid & dout_ready;
    assign busy        = (r_state != ST_IDLE);
    // A stale pulse must never leak out while the unit is frozen.
    assign done        = r_done & enable;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            param_addr <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            r_done     <= 1'b0;
        end else if (!enable) begin
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (read_params) begin
                        param_addr <= '0;
                        r_state    <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    dout       <= param_data;
                    dout_valid <= 1'b1;
                    r_state    <= ST_PRESENT;
                end
                ST_PRESENT: begin
                    if (w_handshake) begin
                        dout_valid <= 1'b0;
                        if (param_addr == C_LAST_ADDR) begin
                            r_done  <= 1'b1;
                            r_state <= ST_WAIT_RELEASE;
                        end else begin
                            param_addr <= param_addr + ADDR_W'(1);
                            r_state    <= ST_FETCH;
                        end
                    end
                end
                ST_WAIT_RELEASE: begin
                    // A held request must drop before another sequence can start.
                    if (!read_params) begin
                        param_addr <= '0;
                        r_state    <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
